// File: rtl/min_search_reader.sv
// min_search_reader
//   Sweeps an inclusive address range of the memory buffer and streams every
//   returned word into Temp_Reg. It also tracks the smallest word seen in
//   Min_Reg and that word's address in Min_Addr. A Start/Done handshake
//   connects it to the control FSM.
//
// Ports
//   Clk          clock, all logic on the rising edge
//   Rst          synchronous reset, active-high
//   Start        1-cycle request, sampled only while idle
//   Start_Addr   first address of the sweep (captured with Start)
//   End_Addr     last address of the sweep, inclusive (captured with Start)
//   Mem_Rd_En    memory read strobe
//   Mem_Addr     memory read address
//   Read_Data    memory read data, valid RD_LAT cycles after Mem_Rd_En
//   Busy         high from the cycle after Start through the Done cycle
//   Done         1-cycle pulse: sweep complete, results stable
//   Range_Err    1-cycle pulse instead of Done when End_Addr < Start_Addr
//   Temp_Reg     last word read
//   Min_Reg      running minimum (unsigned)
//   Min_Addr     address of Min_Reg
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for Start
// ISSUE  | one read strobe per cycle, address incrementing
// DRAIN  | all reads issued, waiting for the last word to return
// FIN    | Done pulse; the results are final
// ERR    | Range_Err pulse for an inverted range; no reads are issued
module min_search_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_Addr,
    input  logic [ADDR_W-1:0] End_Addr,
    output logic              Mem_Rd_En,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Read_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Range_Err,
    output logic [DATA_W-1:0] Temp_Reg,
    output logic [DATA_W-1:0] Min_Reg,
    output logic [ADDR_W-1:0] Min_Addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN,
        S_ERR
    } state_t;

    typedef logic [RD_LAT-1:0] vld_t;

    // Only the oldest read is still in flight: its data is on Read_Data now.
    localparam vld_t VLD_LAST = vld_t'(1) << (RD_LAT - 1);

    state_t            state;
    // One bit wider than the address, so End_Addr = all-ones ends the sweep
    // instead of wrapping back to zero.
    logic [ADDR_W:0]   next_addr;
    logic [ADDR_W:0]   end_addr;
    vld_t              vld_pipe;
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            next_addr <= '0;
            end_addr  <= '0;
            vld_pipe  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe[i] <= '0;
            end
            Mem_Rd_En <= 1'b0;
            Mem_Addr  <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Range_Err <= 1'b0;
            Temp_Reg  <= '0;
            Min_Reg   <= '1;
            Min_Addr  <= '0;
        end else begin
            // Each read strobe and its address travel down the pipe.
            // They reach the last stage in the cycle the word returns.
            vld_pipe[0]  <= Mem_Rd_En;
            addr_pipe[0] <= Mem_Addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end

            if (vld_pipe[RD_LAT-1]) begin
                Temp_Reg <= Read_Data;
                // Strict compare: on a tie, keep the earlier address.
                if (Read_Data < Min_Reg) begin
                    Min_Reg  <= Read_Data;
                    Min_Addr <= addr_pipe[RD_LAT-1];
                end
            end

            Done      <= 1'b0;
            Range_Err <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (End_Addr < Start_Addr) begin
                            Range_Err <= 1'b1;
                            state     <= S_ERR;
                        end else begin
                            Min_Reg   <= '1;
                            Min_Addr  <= Start_Addr;
                            end_addr  <= {1'b0, End_Addr};
                            next_addr <= {1'b0, Start_Addr} + 1'b1;
                            Mem_Rd_En <= 1'b1;
                            Mem_Addr  <= Start_Addr;
                            Busy      <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (next_addr > end_addr) begin
                        Mem_Rd_En <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        Mem_Addr  <= next_addr[ADDR_W-1:0];
                        next_addr <= next_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The last word is captured above on this same edge, so
                    // the results are already final when Done rises.
                    if (vld_pipe == VLD_LAST) begin
                        Done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
